// File: rtl/video_timing_pkg.sv
// Shared types and constants for the parallel-video timing transmitter.
// Holds timing presets, the FSM state type and the colour-bar table.
package video_timing_pkg;

  localparam int CNT_W = 13;

  typedef struct packed {
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_back;
    logic [CNT_W-1:0] h_disp;
    logic [CNT_W-1:0] h_front;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_back;
    logic [CNT_W-1:0] v_disp;
    logic [CNT_W-1:0] v_front;
    logic             hs_pol;
    logic             vs_pol;
  } timing_t;

  localparam timing_t TIMING_720P60 = '{
    h_sync: 13'd40, h_back: 13'd220, h_disp: 13'd1280, h_front: 13'd110,
    v_sync: 13'd5,  v_back: 13'd20,  v_disp: 13'd720,  v_front: 13'd5,
    hs_pol: 1'b1,   vs_pol: 1'b1
  };

  localparam timing_t TIMING_1080P60 = '{
    h_sync: 13'd44, h_back: 13'd148, h_disp: 13'd1920, h_front: 13'd88,
    v_sync: 13'd5,  v_back: 13'd36,  v_disp: 13'd1080, v_front: 13'd4,
    hs_pol: 1'b1,   vs_pol: 1'b1
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Index 0 is the leftmost bar (white).
  localparam logic [7:0][23:0] COLOR_BARS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/video_sync_counter.sv
// Horizontal/vertical raster counters with wrap and region flags.
// Counters are held at zero while run is low.
module video_sync_counter
  import video_timing_pkg::*;
#(
  parameter int H_SYNC  = 40,
  parameter int H_BACK  = 220,
  parameter int H_DISP  = 1280,
  parameter int H_FRONT = 110,
  parameter int V_SYNC  = 5,
  parameter int V_BACK  = 20,
  parameter int V_DISP  = 720,
  parameter int V_FRONT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             h_active,
  output logic             v_active,
  output logic             h_sync,
  output logic             v_sync,
  output logic             frame_end
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_end, v_end;

  always_comb begin
    h_end   = (h_cnt_q == CNT_W'(H_TOTAL - 1));
    v_end   = (v_cnt_q == CNT_W'(V_TOTAL - 1));
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_end) begin
      h_cnt_d = '0;
      v_cnt_d = v_end ? '0 : v_cnt_q + CNT_W'(1);
    end else begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    h_sync    = (h_cnt_q < CNT_W'(H_SYNC));
    v_sync    = (v_cnt_q < CNT_W'(V_SYNC));
    h_active  = (h_cnt_q >= CNT_W'(H_SYNC + H_BACK)) &&
                (h_cnt_q <  CNT_W'(H_SYNC + H_BACK + H_DISP));
    v_active  = (v_cnt_q >= CNT_W'(V_SYNC + V_BACK)) &&
                (v_cnt_q <  CNT_W'(V_SYNC + V_BACK + V_DISP));
    frame_end = h_end && v_end;
  end

  assign h_cnt = h_cnt_q;
  assign v_cnt = v_cnt_q;

endmodule

// File: rtl/video_timing_tx.sv
// Parallel-video source: HS/VS/DE/RGB888 with a one-cycle-ahead pixel request.
// Define VIDEO_TIMING_TX_TPG_EN to replace pixel_data with 8 colour bars.
module video_timing_tx
  import video_timing_pkg::*;
#(
  parameter int H_SYNC  = 40,
  parameter int H_BACK  = 220,
  parameter int H_DISP  = 1280,
  parameter int H_FRONT = 110,
  parameter int V_SYNC  = 5,
  parameter int V_BACK  = 20,
  parameter int V_DISP  = 720,
  parameter int V_FRONT = 5,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1
) (
  input  logic             pixel_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic [23:0]      pixel_data,
  output logic             data_req,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic             video_hs,
  output logic             video_vs,
  output logic             video_de,
  output logic [23:0]      video_rgb,
  output logic             frame_start,
  output logic             busy
);

  localparam logic [CNT_W-1:0] FIRST_REQ = CNT_W'(H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] LAST_X    = CNT_W'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [CNT_W-1:0] FIRST_Y   = CNT_W'(V_SYNC + V_BACK);

  state_e           state_q, state_d;
  logic             running;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_active, v_active, h_sync, v_sync, frame_end;

  logic             busy_d, frame_start_d, data_req_d, hs_d, vs_d, de_d;
  logic [CNT_W-1:0] xpos_d, ypos_d;
  logic [23:0]      rgb_d, pix;

  logic             busy_q, frame_start_q, data_req_q, hs_q, vs_q, de_q;
  logic [CNT_W-1:0] xpos_q, ypos_q;
  logic [23:0]      rgb_q;

  assign running = (state_q == ST_RUN);

  video_sync_counter #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_FRONT(V_FRONT)
  ) u_cnt (
    .clk       (pixel_clk),
    .rst_n     (sys_rst_n),
    .run       (running),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .h_active  (h_active),
    .v_active  (v_active),
    .h_sync    (h_sync),
    .v_sync    (v_sync),
    .frame_end (frame_end)
  );

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Stopping is only honoured at the frame wrap so no partial frame leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (frame_end && !en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d        = (state_d == ST_RUN);
    frame_start_d = (!running && en) || (running && frame_end && en);
  end

  // Request window is the active span shifted one pixel earlier.
  always_comb begin
    data_req_d = running && v_active &&
                 ((h_active && (h_cnt != LAST_X)) || (h_cnt == FIRST_REQ));
    xpos_d     = data_req_d ? h_cnt - FIRST_REQ : '0;
    ypos_d     = data_req_d ? v_cnt - FIRST_Y   : '0;
    hs_d       = (running && h_sync) ? HS_POL : ~HS_POL;
    vs_d       = (running && v_sync) ? VS_POL : ~VS_POL;
    de_d       = data_req_q;
    rgb_d      = data_req_q ? pix : '0;
  end

`ifdef VIDEO_TIMING_TX_TPG_EN
  localparam int BAR_W = (H_DISP / 8 > 0) ? H_DISP / 8 : 1;
  logic [CNT_W-1:0] bar_idx;
  always_comb begin
    bar_idx = xpos_q / CNT_W'(BAR_W);
    pix     = COLOR_BARS[(bar_idx > CNT_W'(7)) ? 3'd7 : bar_idx[2:0]];
  end
`else
  assign pix = pixel_data;
`endif

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      data_req_q    <= 1'b0;
      xpos_q        <= '0;
      ypos_q        <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
    end else begin
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
      data_req_q    <= data_req_d;
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
    end
  end

  assign busy        = busy_q;
  assign frame_start = frame_start_q;
  assign data_req    = data_req_q;
  assign pixel_xpos  = xpos_q;
  assign pixel_ypos  = ypos_q;
  assign video_hs    = hs_q;
  assign video_vs    = vs_q;
  assign video_de    = de_q;
  assign video_rgb   = rgb_q;

endmodule
